// File: rtl/vector_cache_pkg.sv
// Shared vector-cache types: write-tag buffer payload and the tag SRAM write bundle.
package vector_cache_pkg;

  localparam int WAY_NUM     = 4;
  localparam int TAG_WIDTH   = 12;
  localparam int INDEX_WIDTH = 8;
  localparam int STARVE_W    = 8;

  // Payload held by each per-channel write-tag buffer.
  typedef struct packed {
    logic [INDEX_WIDTH-1:0] index;
    logic [TAG_WIDTH-1:0]   tag;
    logic [WAY_NUM-1:0]     way_oh;
  } wr_buf_pld_t;

  // One tag SRAM write: set address, way mask, tag and valid bit.
  typedef struct packed {
    logic [INDEX_WIDTH-1:0] addr;
    logic [WAY_NUM-1:0]     way_oh;
    logic [TAG_WIDTH-1:0]   tag;
    logic                   valid;
  } tag_ram_wr_t;

  // A buffer entry always installs a valid line.
  function automatic tag_ram_wr_t pld_to_wr(input wr_buf_pld_t p);
    tag_ram_wr_t w;
    w.addr   = p.index;
    w.way_oh = p.way_oh;
    w.tag    = p.tag;
    w.valid  = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/vec_cache_tag_wr_ctrl_if.sv
// Bus between the write-tag buffers / lookup side and the tag write controller.
// Handshake: a buffer holds tag_buf_vld/pld stable until it sees its tag_buf_rdy
// bit high in a cycle; that cycle is the transfer, and vld drops on the next edge.
interface vec_cache_tag_wr_ctrl_if #(
  parameter int REQ_NUM = 4
);
  import vector_cache_pkg::*;
  localparam int ID_W = $clog2(REQ_NUM);

  logic [REQ_NUM-1:0]     tag_buf_vld;
  wr_buf_pld_t            tag_buf_pld [REQ_NUM];
  logic [REQ_NUM-1:0]     tag_buf_rdy;
  logic                   rd_busy;
  logic                   lookup_stall;
  logic                   tag_ram_wr_en;
  logic [INDEX_WIDTH-1:0] tag_ram_wr_addr;
  logic [WAY_NUM-1:0]     tag_ram_wr_way_oh;
  logic [TAG_WIDTH-1:0]   tag_ram_wr_tag;
  logic                   tag_ram_wr_valid;
  logic [ID_W-1:0]        wr_done_id;
  logic [ID_W-1:0]        dbg_rr_ptr;
  logic [STARVE_W-1:0]    dbg_starve_cnt;

  modport master (
    output tag_buf_vld, tag_buf_pld, rd_busy,
    input  tag_buf_rdy, lookup_stall, tag_ram_wr_en, tag_ram_wr_addr,
           tag_ram_wr_way_oh, tag_ram_wr_tag, tag_ram_wr_valid, wr_done_id,
           dbg_rr_ptr, dbg_starve_cnt
  );

  modport slave (
    input  tag_buf_vld, tag_buf_pld, rd_busy,
    output tag_buf_rdy, lookup_stall, tag_ram_wr_en, tag_ram_wr_addr,
           tag_ram_wr_way_oh, tag_ram_wr_tag, tag_ram_wr_valid, wr_done_id,
           dbg_rr_ptr, dbg_starve_cnt
  );

endinterface

// File: rtl/vec_cache_rr_arb.sv
// Round-robin arbiter: grants the first request at or after the pointer,
// then moves the pointer just past the winner.
module vec_cache_rr_arb #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         i_req,
  input  logic                 i_en,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_grant_id,
  output logic [$clog2(N)-1:0] o_ptr
);
  localparam int ID_W = $clog2(N);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_idx;
  logic            w_found;

  // Scan requests starting at the pointer, wrapping modulo N.
  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    w_found    = 1'b0;
    w_sum      = '0;
    w_idx      = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
      w_idx = (w_sum >= (ID_W+1)'(N)) ? ID_W'(w_sum - (ID_W+1)'(N)) : ID_W'(w_sum);
      if (i_en && !w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_id     = w_idx;
      end
    end
  end

  // Pointer moves past the winner on a grant, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (o_grant_id == ID_W'(N-1)) ? '0 : o_grant_id + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/vec_cache_tag_wr_ctrl.sv
// Tag SRAM write controller: arbitrates write-tag buffers, yields to lookup
// reads, and forces a write slot after STARVE_MAX blocked cycles.
module vec_cache_tag_wr_ctrl
  import vector_cache_pkg::*;
#(
  parameter int REQ_NUM    = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  vec_cache_tag_wr_ctrl_if.slave  bus
);
  localparam int ID_W = $clog2(REQ_NUM);

  logic [REQ_NUM-1:0]  w_grant;
  logic [ID_W-1:0]     w_grant_id;
  logic [ID_W-1:0]     w_ptr;
  logic                w_any_req;
  logic                w_force;
  logic                w_blocked;
  logic                w_grant_vld;
  logic [STARVE_W-1:0] r_starve_cnt;
  logic                r_wr_en;
  tag_ram_wr_t         r_wr;
  logic [ID_W-1:0]     r_done_id;

  assign w_any_req   = |bus.tag_buf_vld;
  assign w_force     = (r_starve_cnt == STARVE_W'(STARVE_MAX));
  assign w_blocked   = bus.rd_busy & ~w_force;
  assign w_grant_vld = |w_grant;

  vec_cache_rr_arb #(.N(REQ_NUM)) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (bus.tag_buf_vld),
    .i_en       (~w_blocked),
    .o_grant    (w_grant),
    .o_grant_id (w_grant_id),
    .o_ptr      (w_ptr)
  );

  // Count cycles a pending request is held off by lookup; saturate at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (w_grant_vld) begin
      r_starve_cnt <= '0;
    end else if (w_any_req && bus.rd_busy) begin
      if (!w_force) r_starve_cnt <= r_starve_cnt + 1'b1;
    end else if (!w_any_req) begin
      r_starve_cnt <= '0;
    end
  end

  // Write stage: the granted payload reaches the SRAM port one cycle after grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr      <= '0;
      r_done_id <= '0;
    end else begin
      r_wr_en <= w_grant_vld;
      if (w_grant_vld) begin
        r_wr      <= pld_to_wr(bus.tag_buf_pld[w_grant_id]);
        r_done_id <= w_grant_id;
      end
    end
  end

  assign bus.tag_buf_rdy       = w_grant;
  assign bus.lookup_stall      = w_force;
  assign bus.tag_ram_wr_en     = r_wr_en;
  assign bus.tag_ram_wr_addr   = r_wr.addr;
  assign bus.tag_ram_wr_way_oh = r_wr.way_oh;
  assign bus.tag_ram_wr_tag    = r_wr.tag;
  assign bus.tag_ram_wr_valid  = r_wr.valid;
  assign bus.wr_done_id        = r_done_id;
  assign bus.dbg_rr_ptr        = w_ptr;
  assign bus.dbg_starve_cnt    = r_starve_cnt;

  a_rdy_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.tag_buf_rdy));
  a_rdy_has_vld: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.tag_buf_rdy & ~bus.tag_buf_vld) == '0);
  a_wr_way_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    bus.tag_ram_wr_en |-> $onehot(bus.tag_ram_wr_way_oh));

endmodule
